// File: rtl/pipe_io_pkg.sv
// rtl/pipe_io_pkg.sv - MMIO addresses, FSM state encoding and 7-seg constants for pipe_io_poller
package pipe_io_pkg;

    localparam logic [31:0] MMIO_SW   = 32'hffff_ff00;
    localparam logic [31:0] MMIO_KEY  = 32'hffff_ff10;
    localparam logic [31:0] MMIO_HEX0 = 32'hffff_ff20;
    localparam logic [31:0] MMIO_HEX1 = 32'hffff_ff30;
    localparam logic [31:0] MMIO_HEX2 = 32'hffff_ff40;
    localparam logic [31:0] MMIO_HEX3 = 32'hffff_ff50;
    localparam logic [31:0] MMIO_HEX4 = 32'hffff_ff60;
    localparam logic [31:0] MMIO_HEX5 = 32'hffff_ff70;
    localparam logic [31:0] MMIO_LED  = 32'hffff_ff80;

    // All segments off (active-low)
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REQ,
        ST_RD_SW,
        ST_RD_SW_W,
        ST_RD_KEY,
        ST_RD_KEY_W,
        ST_WR_H0,
        ST_WR_H1,
        ST_WR_H2,
        ST_WR_H5,
        ST_WR_LED,
        ST_DONE
    } state_e;

endpackage

// File: rtl/seg7_encoder.sv
// rtl/seg7_encoder.sv - combinational hex digit to active-low 7-segment pattern (bit0 = segment a)
module seg7_encoder
    import pipe_io_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Segment lookup, one pattern per hex digit
    always_comb begin
        seg_o = SEG_BLANK;
        case (hex_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/pipe_io_poller.sv
// rtl/pipe_io_poller.sv - periodic MMIO bus initiator polling switches/keys and driving 7-seg digits (optional LED write: PIPE_IO_POLLER_LED_EN)
module pipe_io_poller
    import pipe_io_pkg::*;
#(
    parameter int PERIOD = 50000,
    parameter int CNT_W  = 16
) (
    input  logic        dmem_clk,
    input  logic        resetn,
    input  logic        bus_gnt,
    input  logic [31:0] dataout,
    output logic        bus_req,
    output logic [31:0] addr,
    output logic [31:0] datain,
    output logic        we,
    output logic [3:0]  key_count,
    output logic        busy
);

    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       sw_q, sw_d;
    logic [2:0]       key_q, key_d;
    logic [3:0]       key_count_q, key_count_d;
    logic             bus_req_q, bus_req_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      datain_q, datain_d;
    logic             we_q, we_d;
    logic [3:0]       seg_nib;
    logic [6:0]       seg_pat;
    logic             gnt_lost;

    // Only sw[9:0] and key[3:1] carry information in the read data
    logic unused_dataout;
    assign unused_dataout = ^{dataout[31:10], dataout[0]};

    seg7_encoder u_seg (
        .hex_i (seg_nib),
        .seg_o (seg_pat)
    );

    // Losing the grant mid-burst aborts the transaction; the request phase just waits
    assign gnt_lost = !bus_gnt && (state_q inside {ST_RD_SW, ST_RD_SW_W, ST_RD_KEY,
                                   ST_RD_KEY_W, ST_WR_H0, ST_WR_H1, ST_WR_H2,
                                   ST_WR_H5, ST_WR_LED});

    // Next state, period counter and captured read data
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        sw_d        = sw_q;
        key_d       = key_q;
        key_count_d = key_count_q;
        case (state_q)
            ST_IDLE: begin
                if (cnt_q == PERIOD_LAST) begin
                    state_d = ST_REQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_REQ:      if (bus_gnt) state_d = ST_RD_SW;
            ST_RD_SW:    state_d = ST_RD_SW_W;
            ST_RD_SW_W: begin
                sw_d    = dataout[9:0];
                state_d = ST_RD_KEY;
            end
            ST_RD_KEY:   state_d = ST_RD_KEY_W;
            ST_RD_KEY_W: begin
                // Keys are active-low: a press is any bit going 1 -> 0; count once per poll
                key_d = dataout[3:1];
                if (|(key_q & ~dataout[3:1])) begin
                    key_count_d = key_count_q + 4'd1;
                end
                state_d = ST_WR_H0;
            end
            ST_WR_H0:    state_d = ST_WR_H1;
            ST_WR_H1:    state_d = ST_WR_H2;
            ST_WR_H2:    state_d = ST_WR_H5;
`ifdef PIPE_IO_POLLER_LED_EN
            ST_WR_H5:    state_d = ST_WR_LED;
            ST_WR_LED:   state_d = ST_DONE;
`else
            ST_WR_H5:    state_d = ST_DONE;
`endif
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        if (gnt_lost) begin
            state_d     = ST_IDLE;
            sw_d        = sw_q;
            key_d       = key_q;
            key_count_d = key_count_q;
        end
    end

    // Digit feeding the shared encoder, chosen by the write about to be issued
    always_comb begin
        seg_nib = sw_q[3:0];
        case (state_d)
            ST_WR_H1: seg_nib = sw_q[7:4];
            ST_WR_H2: seg_nib = {2'b00, sw_q[9:8]};
            ST_WR_H5: seg_nib = key_count_q;
            default:  seg_nib = sw_q[3:0];
        endcase
    end

    // Bus outputs are registered alongside the state they belong to
    always_comb begin
        bus_req_d = 1'b0;
        addr_d    = 32'h0;
        datain_d  = 32'h0;
        we_d      = 1'b0;
        case (state_d)
            ST_REQ: bus_req_d = 1'b1;
            ST_RD_SW, ST_RD_SW_W: begin
                bus_req_d = 1'b1;
                addr_d    = MMIO_SW;
            end
            ST_RD_KEY, ST_RD_KEY_W: begin
                bus_req_d = 1'b1;
                addr_d    = MMIO_KEY;
            end
            ST_WR_H0, ST_WR_H1, ST_WR_H2, ST_WR_H5: begin
                bus_req_d = 1'b1;
                we_d      = 1'b1;
                datain_d  = {25'b0, seg_pat};
                addr_d    = (state_d == ST_WR_H0) ? MMIO_HEX0 :
                            (state_d == ST_WR_H1) ? MMIO_HEX1 :
                            (state_d == ST_WR_H2) ? MMIO_HEX2 : MMIO_HEX5;
            end
`ifdef PIPE_IO_POLLER_LED_EN
            ST_WR_LED: begin
                bus_req_d = 1'b1;
                we_d      = 1'b1;
                addr_d    = MMIO_LED;
                datain_d  = {22'b0, sw_q};
            end
`endif
            default: ;
        endcase
    end

    // State and output registers
    always_ff @(posedge dmem_clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sw_q        <= 10'h0;
            key_q       <= 3'b111;
            key_count_q <= 4'h0;
            bus_req_q   <= 1'b0;
            addr_q      <= 32'h0;
            datain_q    <= 32'h0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sw_q        <= sw_d;
            key_q       <= key_d;
            key_count_q <= key_count_d;
            bus_req_q   <= bus_req_d;
            addr_q      <= addr_d;
            datain_q    <= datain_d;
            we_q        <= we_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign addr      = addr_q;
    assign datain    = datain_q;
    assign we        = we_q;
    assign key_count = key_count_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
